// File: rtl/keypad_code_entry.sv
// -----------------------------------------------------------------------------
// keypad_code_entry
//
// Front end for the home-automation authorization checker. Four serially
// keyed bits are shifted into a 4-bit code (first key ends up in the MSB).
// The code is then presented with a one-cycle validate strobe. The checker's
// registered auth_status is sampled one cycle later and reported as a
// granted/denied pulse. Consecutive denials are counted. Reaching MAX_FAILS
// starts a timed lockout. A partial entry that sits idle too long is dropped.
//
// Parameters:
//   TIMEOUT_CYCLES  idle cycles allowed between keys of a partial entry (1..65535)
//   MAX_FAILS       consecutive denials that trigger lockout (1..15)
//   LOCK_CYCLES     lockout duration in cycles (1..65535)
//
// Ports:
//   clk            in   clock, rising edge
//   reset          in   asynchronous, active-high reset
//   key_valid      in   one key press this cycle
//   key_bit        in   key value, qualified by key_valid
//   key_clear      in   discard the partial entry
//   auth_status    in   checker result, registered by the checker on validate
//   code           out  assembled code to the checker
//   validate       out  one-cycle submit strobe
//   granted        out  one-cycle pulse, access granted
//   denied         out  one-cycle pulse, access denied
//   entry_timeout  out  one-cycle pulse, partial entry discarded by timeout
//   locked         out  high during lockout
//   busy           out  high while keys are ignored (SUBMIT, CHECK, LOCKED)
//   fail_count     out  current consecutive-failure count
// -----------------------------------------------------------------------------
module keypad_code_entry #(
    parameter int unsigned TIMEOUT_CYCLES = 1000,
    parameter int unsigned MAX_FAILS      = 3,
    parameter int unsigned LOCK_CYCLES    = 5000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       key_valid,
    input  logic       key_bit,
    input  logic       key_clear,
    input  logic       auth_status,
    output logic [3:0] code,
    output logic       validate,
    output logic       granted,
    output logic       denied,
    output logic       entry_timeout,
    output logic       locked,
    output logic       busy,
    output logic [3:0] fail_count
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ENTRY  = 3'd1,
        S_SUBMIT = 3'd2,
        S_CHECK  = 3'd3,
        S_LOCKED = 3'd4
    } state_t;

    // Terminal timer values; both are below 65536 so the 16-bit timer never wraps.
    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);
    localparam logic [15:0] LOCK_LAST    = 16'(LOCK_CYCLES - 1);
    localparam logic [3:0]  MAX_F        = 4'(MAX_FAILS);

    state_t      state_q, state_d;
    logic [3:0]  code_q, code_d;
    logic [2:0]  count_q, count_d;
    logic [15:0] timer_q, timer_d;
    logic [3:0]  fail_q, fail_d;
    logic [3:0]  fail_inc;

    logic        timeout_ev, grant_ev, deny_ev;

    logic        validate_q, validate_d;
    logic        granted_q, granted_d;
    logic        denied_q, denied_d;
    logic        timeout_q, timeout_d;
    logic        locked_q, locked_d;
    logic        busy_q, busy_d;

    // Saturating increment of the failure counter.
    assign fail_inc = (fail_q < MAX_F) ? fail_q + 4'd1 : fail_q;

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            code_q     <= 4'd0;
            count_q    <= 3'd0;
            timer_q    <= 16'd0;
            fail_q     <= 4'd0;
            validate_q <= 1'b0;
            granted_q  <= 1'b0;
            denied_q   <= 1'b0;
            timeout_q  <= 1'b0;
            locked_q   <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            code_q     <= code_d;
            count_q    <= count_d;
            timer_q    <= timer_d;
            fail_q     <= fail_d;
            validate_q <= validate_d;
            granted_q  <= granted_d;
            denied_q   <= denied_d;
            timeout_q  <= timeout_d;
            locked_q   <= locked_d;
            busy_q     <= busy_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and datapath logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        code_d     = code_q;
        count_d    = count_q;
        timer_d    = timer_q;
        fail_d     = fail_q;
        timeout_ev = 1'b0;
        grant_ev   = 1'b0;
        deny_ev    = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                // Clear beats a simultaneous key; the key is dropped.
                if (key_clear) begin
                    code_d  = 4'd0;
                    count_d = 3'd0;
                    timer_d = 16'd0;
                end else if (key_valid) begin
                    code_d  = {code_q[2:0], key_bit};
                    count_d = 3'd1;
                    timer_d = 16'd0;
                    state_d = S_ENTRY;
                end
            end

            S_ENTRY: begin
                if (key_clear) begin
                    code_d  = 4'd0;
                    count_d = 3'd0;
                    timer_d = 16'd0;
                    state_d = S_IDLE;
                end else if (key_valid) begin
                    // A key on the expiry cycle still counts and restarts the timer.
                    code_d  = {code_q[2:0], key_bit};
                    timer_d = 16'd0;
                    if (count_q == 3'd3) begin
                        count_d = 3'd0;
                        state_d = S_SUBMIT;
                    end else begin
                        count_d = count_q + 3'd1;
                    end
                end else if (timer_q == TIMEOUT_LAST) begin
                    code_d     = 4'd0;
                    count_d    = 3'd0;
                    timer_d    = 16'd0;
                    timeout_ev = 1'b1;
                    state_d    = S_IDLE;
                end else begin
                    timer_d = timer_q + 16'd1;
                end
            end

            // code is held while the checker registers it.
            S_SUBMIT: state_d = S_CHECK;

            S_CHECK: begin
                code_d = 4'd0;
                if (auth_status) begin
                    grant_ev = 1'b1;
                    fail_d   = 4'd0;
                    state_d  = S_IDLE;
                end else begin
                    deny_ev = 1'b1;
                    fail_d  = fail_inc;
                    if (fail_inc == MAX_F) begin
                        timer_d = 16'd0;
                        state_d = S_LOCKED;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end

            S_LOCKED: begin
                if (timer_q == LOCK_LAST) begin
                    timer_d = 16'd0;
                    fail_d  = 4'd0;
                    state_d = S_IDLE;
                end else begin
                    timer_d = timer_q + 16'd1;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Output logic. The outputs are computed from the upcoming state so
    // that, once registered, they line up with the state they describe.
    // ------------------------------------------------------------------
    always_comb begin
        validate_d = (state_d == S_SUBMIT);
        granted_d  = grant_ev;
        denied_d   = deny_ev;
        timeout_d  = timeout_ev;
        locked_d   = (state_d == S_LOCKED);
        busy_d     = (state_d == S_SUBMIT) || (state_d == S_CHECK) || (state_d == S_LOCKED);
    end

    assign code          = code_q;
    assign validate      = validate_q;
    assign granted       = granted_q;
    assign denied        = denied_q;
    assign entry_timeout = timeout_q;
    assign locked        = locked_q;
    assign busy          = busy_q;
    assign fail_count    = fail_q;

endmodule

// File: tb/tb_keypad_code_entry.sv
`timescale 1ns/1ps
module tb_keypad_code_entry;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       key_valid = 1'b0;
    logic       key_bit = 1'b0;
    logic       key_clear = 1'b0;
    logic       auth_status;
    logic [3:0] code;
    logic       validate, granted, denied, entry_timeout, locked, busy;
    logic [3:0] fail_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    keypad_code_entry #(
        .TIMEOUT_CYCLES(5),
        .MAX_FAILS     (3),
        .LOCK_CYCLES   (8)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .key_valid    (key_valid),
        .key_bit      (key_bit),
        .key_clear    (key_clear),
        .auth_status  (auth_status),
        .code         (code),
        .validate     (validate),
        .granted      (granted),
        .denied       (denied),
        .entry_timeout(entry_timeout),
        .locked       (locked),
        .busy         (busy),
        .fail_count   (fail_count)
    );

    // Checker model: accepts 1010, registers its result on validate.
    always @(posedge clk or posedge reset) begin
        if (reset) auth_status <= 1'b0;
        else if (validate) auth_status <= (code == 4'b1010);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input logic b);
        key_valid = 1'b1;
        key_bit   = b;
        step();
        key_valid = 1'b0;
    endtask

    // Four keys on consecutive edges, MSB first; returns 1 ns after the 4th edge.
    task automatic enter(input logic [3:0] c);
        for (int i = 3; i >= 0; i--) press(c[i]);
    endtask

    function automatic logic [13:0] outs();
        return {code, validate, granted, denied, entry_timeout, locked, busy, fail_count};
    endfunction

    // Enter 1010 and expect validate at E and granted at E+2.
    task automatic expect_grant(input string tag);
        enter(4'b1010);
        checks++;
        if (validate !== 1'b1 || code !== 4'b1010) begin
            errors++;
            $display("FAIL %s_submit: validate=%b code=%b, required validate=1 code=1010", tag, validate, code);
        end
        step();
        step();
        checks++;
        if (granted !== 1'b1 || denied !== 1'b0 || fail_count !== 4'd0 || code !== 4'd0) begin
            errors++;
            $display("FAIL %s_grant: granted=%b denied=%b fail=%0d code=%b, required 1 0 0 0000",
                     tag, granted, denied, fail_count, code);
        end
        $display("txn %s: code 1010 -> granted=%b fail_count=%0d", tag, granted, fail_count);
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if (outs() !== 14'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %b, required all zero", outs());
        end
        step();
        step();
        reset = 1'b0;
        step();
        checks++;
        if (outs() !== 14'd0) begin
            errors++;
            $display("FAIL post_reset_idle: got %b, required all zero", outs());
        end
        $display("txn reset: outputs=%b", outs());
    endtask

    task automatic test_correct_code();
        enter(4'b1010);
        checks++;
        if (validate !== 1'b1 || code !== 4'b1010 || busy !== 1'b1) begin
            errors++;
            $display("FAIL correct_submit: validate=%b code=%b busy=%b, required 1 1010 1", validate, code, busy);
        end
        step();
        checks++;
        if (validate !== 1'b0 || granted !== 1'b0 || code !== 4'b1010) begin
            errors++;
            $display("FAIL correct_check: validate=%b granted=%b code=%b, required 0 0 1010", validate, granted, code);
        end
        step();
        checks++;
        if (granted !== 1'b1 || fail_count !== 4'd0 || code !== 4'd0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL correct_grant: granted=%b fail=%0d code=%b busy=%b, required 1 0 0000 0",
                     granted, fail_count, code, busy);
        end
        step();
        checks++;
        if (granted !== 1'b0) begin
            errors++;
            $display("FAIL correct_grant_width: granted=%b, required 0", granted);
        end
        $display("txn correct_code: code 1010 -> granted");
    endtask

    task automatic test_lockout();
        logic [3:0] n;
        int         cnt;
        for (int a = 1; a <= 3; a++) begin
            n = 4'(a);
            enter(4'b0011);
            step();
            step();
            checks++;
            if (denied !== 1'b1 || granted !== 1'b0 || fail_count !== n || locked !== (a == 3)) begin
                errors++;
                $display("FAIL lockout_deny%0d: denied=%b fail=%0d locked=%b, required 1 %0d %b",
                         a, denied, fail_count, locked, n, (a == 3));
            end
            $display("txn lockout attempt %0d: code 0011 -> denied=%b fail_count=%0d", a, denied, fail_count);
        end
        // Hold a key down through the lockout; it must be ignored.
        cnt       = 1;
        key_valid = 1'b1;
        key_bit   = 1'b1;
        for (int i = 0; i < 100; i++) begin
            step();
            if (locked) cnt++;
            else break;
        end
        key_valid = 1'b0;
        checks++;
        if (cnt !== 8) begin
            errors++;
            $display("FAIL lockout_length: locked %0d cycles, required 8", cnt);
        end
        checks++;
        if (fail_count !== 4'd0 || code !== 4'd0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL lockout_exit: fail=%0d code=%b busy=%b, required 0 0000 0", fail_count, code, busy);
        end
        $display("txn lockout: locked for %0d cycles", cnt);
        expect_grant("after_lock");
    endtask

    task automatic test_timeout();
        press(1'b1);
        press(1'b0);
        for (int i = 0; i < 4; i++) step();
        checks++;
        if (entry_timeout !== 1'b0 || code !== 4'b0010) begin
            errors++;
            $display("FAIL timeout_early: entry_timeout=%b code=%b, required 0 0010", entry_timeout, code);
        end
        step();
        checks++;
        if (entry_timeout !== 1'b1 || code !== 4'd0) begin
            errors++;
            $display("FAIL timeout_pulse: entry_timeout=%b code=%b, required 1 0000", entry_timeout, code);
        end
        step();
        checks++;
        if (entry_timeout !== 1'b0) begin
            errors++;
            $display("FAIL timeout_width: entry_timeout=%b, required 0", entry_timeout);
        end
        $display("txn timeout: partial 10 discarded");
        expect_grant("after_timeout");
        step();
        // Key on the expiry cycle is accepted and suppresses the pulse.
        press(1'b1);
        press(1'b0);
        for (int i = 0; i < 4; i++) step();
        press(1'b1);
        checks++;
        if (entry_timeout !== 1'b0 || code !== 4'b0101) begin
            errors++;
            $display("FAIL timeout_key_wins: entry_timeout=%b code=%b, required 0 0101", entry_timeout, code);
        end
        press(1'b0);
        checks++;
        if (validate !== 1'b1 || code !== 4'b1010) begin
            errors++;
            $display("FAIL timeout_key_submit: validate=%b code=%b, required 1 1010", validate, code);
        end
        step();
        step();
        checks++;
        if (granted !== 1'b1) begin
            errors++;
            $display("FAIL timeout_key_grant: granted=%b, required 1", granted);
        end
        $display("txn expiry_key: key on expiry cycle accepted -> granted=%b", granted);
    endtask

    task automatic test_clear();
        step();
        press(1'b1);
        press(1'b0);
        key_clear = 1'b1;
        key_valid = 1'b1;
        key_bit   = 1'b1;
        step();
        key_clear = 1'b0;
        key_valid = 1'b0;
        checks++;
        if (code !== 4'd0 || busy !== 1'b0 || validate !== 1'b0) begin
            errors++;
            $display("FAIL clear_priority: code=%b busy=%b validate=%b, required 0000 0 0", code, busy, validate);
        end
        $display("txn clear: entry discarded, code=%b", code);
        expect_grant("after_clear");
    endtask

    task automatic test_fail_reset();
        step();
        enter(4'b0000);
        step();
        step();
        checks++;
        if (denied !== 1'b1 || fail_count !== 4'd1 || locked !== 1'b0) begin
            errors++;
            $display("FAIL fail_reset_deny: denied=%b fail=%0d locked=%b, required 1 1 0", denied, fail_count, locked);
        end
        $display("txn fail_reset: code 0000 -> denied fail_count=%0d", fail_count);
        expect_grant("fail_reset");
    endtask

    task automatic test_reset_mid();
        step();
        // Reset while in SUBMIT.
        enter(4'b1010);
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (outs() !== 14'd0) begin
            errors++;
            $display("FAIL reset_submit: outputs=%b, required all zero", outs());
        end
        step();
        reset = 1'b0;
        step();
        step();
        checks++;
        if (granted !== 1'b0 || denied !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_submit_after: granted=%b denied=%b busy=%b, required 0 0 0", granted, denied, busy);
        end
        $display("txn reset_in_submit: outputs cleared");
        // Reset while in CHECK.
        enter(4'b1010);
        step();
        reset = 1'b1;
        #1;
        checks++;
        if (outs() !== 14'd0) begin
            errors++;
            $display("FAIL reset_check: outputs=%b, required all zero", outs());
        end
        step();
        reset = 1'b0;
        step();
        checks++;
        if (granted !== 1'b0 || denied !== 1'b0) begin
            errors++;
            $display("FAIL reset_check_after: granted=%b denied=%b, required 0 0", granted, denied);
        end
        $display("txn reset_in_check: outputs cleared");
        expect_grant("after_reset");
    endtask

    initial begin
        test_reset();
        test_correct_code();
        test_lockout();
        test_timeout();
        test_clear();
        test_fail_reset();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/keypad_code_entry.md
# keypad_code_entry

- Front-end submitter for the home-automation authorization checker.
- Collects four serially keyed code bits from the keypad into a 4-bit code.
- Presents the code with a one-cycle `validate` strobe, then samples the checker's registered `auth_status` and reports granted/denied.
- Counts consecutive failures and enforces a timed lockout; discards stale partial entries after an inactivity timeout.

## Interface

Parameters:
- `TIMEOUT_CYCLES`, default 1000. Idle cycles allowed between keys of a partial entry. Range 1..65535.
- `MAX_FAILS`, default 3. Consecutive denials that trigger lockout. Range 1..15.
- `LOCK_CYCLES`, default 5000. Lockout duration in cycles. Range 1..65535.

Ports:
- `clk` in 1: clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `key_valid` in 1: one key press this cycle.
- `key_bit` in 1: key value, qualified by `key_valid`.
- `key_clear` in 1: discard the partial entry.
- `auth_status` in 1: checker result, registered by the checker on `validate`.
- `code` out 4: assembled code to the checker.
- `validate` out 1: one-cycle submit strobe to the checker.
- `granted` out 1: one-cycle pulse, access granted.
- `denied` out 1: one-cycle pulse, access denied.
- `entry_timeout` out 1: one-cycle pulse, partial entry discarded by timeout.
- `locked` out 1: high during lockout.
- `busy` out 1: high while keys are ignored (states SUBMIT, CHECK, LOCKED).
- `fail_count` out 4: current consecutive-failure count.

## Operation

- States: IDLE, ENTRY, SUBMIT, CHECK, LOCKED.
- Reset values: state IDLE; `code`, key count and timer all 0; every output 0.

Key entry:
- The shift register updates as `code <= {code[2:0], key_bit}`, so the first key lands in the MSB.
- IDLE: `key_valid` shifts in a bit, sets count to 1, moves to ENTRY and clears the timer.
- ENTRY: `key_valid` shifts in a bit and clears the timer.
  - When the 4th key is accepted, go to SUBMIT.
  - Without a key, the timer increments.
  - When the timer reaches `TIMEOUT_CYCLES`-1 with no key: clear `code` and count, pulse `entry_timeout`, return to IDLE.
- `key_clear` in IDLE or ENTRY clears `code`, count and timer and returns to IDLE.
  - It has priority over `key_valid` in the same cycle; that key is dropped.
- `key_valid` wins over timeout expiry in the same cycle.
- `key_valid` and `key_clear` are ignored in SUBMIT, CHECK and LOCKED.

Submit and check:
- SUBMIT: `validate`=1 for exactly one cycle; `code` is held stable. Next state is CHECK.
- CHECK: sample `auth_status`.
  - 1: pulse `granted`, clear `fail_count`, go to IDLE.
  - 0: pulse `denied`, increment `fail_count`.
    - If the new count equals `MAX_FAILS`, go to LOCKED and clear the timer.
    - Otherwise go to IDLE.
  - In either case `code` is cleared to 0 on leaving CHECK.

Lockout:
- LOCKED: `locked`=1. The timer counts up to `LOCK_CYCLES`-1, then `fail_count` clears to 0 and the state returns to IDLE.

Width rules:
- The timer is 16-bit and never wraps, because its terminal values are below 65536.
- `fail_count` saturates at `MAX_FAILS`.

## Timing

- All outputs are registered.
- For a 4th key accepted at edge E:
  - `validate` is high from E to E+1.
  - The checker registers its result at E+1.
  - `auth_status` is sampled at E+2.
  - `granted`/`denied` are high from E+2 to E+3, together with the `fail_count` update and `locked` rising.
- Key-to-result latency is 2 cycles; the next key can be accepted at edge E+3 at the earliest.
- Timeout: with the last key at edge K and no further key, `entry_timeout` is high from K+`TIMEOUT_CYCLES` to the following edge.
- `locked` stays high for exactly `LOCK_CYCLES` cycles.
- `busy` equals (state ∈ {SUBMIT, CHECK, LOCKED}).
- Reset asserted in any state, including mid-entry, SUBMIT, CHECK and LOCKED, immediately forces the reset values.
  - A `validate` pulse in progress is truncated.
  - No `granted`/`denied` pulse is produced for the aborted attempt.

## Test plan

1. Correct code, bench checker expecting 1010: keys 1,0,1,0 on consecutive cycles -> `validate` one cycle with `code`=4'b1010; `granted` 2 cycles after the 4th key; `fail_count`=0; `code` returns to 0.
2. Wrong code with `MAX_FAILS`=3, `LOCK_CYCLES`=8: enter 0011 three times -> `denied` ×3 with `fail_count` 1,2,3; `locked`=1 for 8 cycles; keys during lockout ignored; then `fail_count`=0, entry 1010 -> `granted`.
3. Timeout with `TIMEOUT_CYCLES`=5: keys 1,0, then idle -> `entry_timeout` pulse 5 cycles after the 2nd key; `code`=0; a subsequent 1010 -> `granted`. Also: a key arriving on the expiry cycle is accepted and no pulse occurs.
4. Clear priority: keys 1,0, then `key_clear`=1 with `key_valid`=1 (bit 1) -> state IDLE, `code`=0; entry 1010 afterwards -> `granted`.
5. Failure reset by success: 0000 (denied, `fail_count`=1), then 1010 -> `granted`, `fail_count`=0.
6. Reset mid-operation: assert `reset` during SUBMIT and separately during CHECK -> all outputs 0 asynchronously, no `granted`/`denied`; after release, 1010 -> `granted`.
